// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial arithmetic unit.
// FSM state encoding plus counter-width helpers.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 8;
  localparam int CNT_W     = $clog2(DEF_WIDTH);

  // Counter width for a given operand width; never below one bit.
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_add_sub_full_adder.sv
// Full adder cell: two half adders chained.
// Carry-out is the OR of both partial carries.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);

  logic w_s0;
  logic w_c0;
  logic w_c1;

  half_adder u_ha0 (
    .i_a (i_a),
    .i_b (i_b),
    .o_s (w_s0),
    .o_c (w_c0)
  );

  half_adder u_ha1 (
    .i_a (w_s0),
    .i_b (i_c),
    .o_s (o_s),
    .o_c (w_c1)
  );

  assign o_c = w_c0 | w_c1;

endmodule

// File: rtl/serial_add_sub_half_adder.sv
// Half adder cell.
// Sum is XOR, carry is AND.
module half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor, one bit per clock, LSB first.
// One full-adder cell plus carry flop; start/busy/done handshake.
module serial_add_sub
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

  state_e           r_state;
  logic [WIDTH-1:0] r_sha;
  logic [WIDTH-1:0] r_shb;
  logic [WIDTH-1:0] r_result;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_ovf_c;
  logic             r_cout;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic w_s;
  logic w_c;

  full_adder u_fa (
    .i_a (r_sha[0]),
    .i_b (r_shb[0]),
    .i_c (r_carry),
    .o_s (w_s),
    .o_c (w_c)
  );

  // FSM, shift datapath and registered flags in one sequential block.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_sha    <= '0;
      r_shb    <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_ovf_c  <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state  <= RUN;
            r_busy   <= 1'b1;
            r_sha    <= a;
            r_shb    <= sub ? ~b : b;
            r_carry  <= sub;
            r_cnt    <= '0;
            r_ovf_c  <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_sha    <= r_sha >> 1;
          r_shb    <= r_shb >> 1;
          r_result <= {w_s, r_result[WIDTH-1:1]};
          r_carry  <= w_c;
          if (r_cnt == PENULT) begin
            r_ovf_c <= w_c;
          end
          if (r_cnt == LAST) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_cout  <= w_c;
            r_ovf   <= w_c ^ r_ovf_c;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign result   = r_result;
  assign cout     = r_cout;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub at WIDTH=8.
// Expected results queued at start, checked on done.
module tb_serial_add_sub;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         v;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;

  int   n_tot = 0;
  int   n_bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  serial_add_sub #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x,
                                 input logic [W-1:0] y,
                                 input logic s);
    exp_t e;
    logic [W:0] t;
    if (!s) begin
      t   = {1'b0, x} + {1'b0, y};
      e.r = t[W-1:0];
      e.c = t[W];
      e.v = (x[W-1] == y[W-1]) && (e.r[W-1] != x[W-1]);
    end else begin
      e.r = x - y;
      e.c = (x >= y);
      e.v = (x[W-1] != y[W-1]) && (e.r[W-1] != x[W-1]);
    end
    return e;
  endfunction

  // Pop and compare on every done pulse.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst === 1'b0 && done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spur_done", 32'(done), 0);
      end else begin
        e = sb.pop_front();
        chk("result", 32'(result), 32'(e.r));
        chk("cout", 32'(cout), 32'(e.c));
        chk("ovf", 32'(overflow), 32'(e.v));
      end
    end
  end

  task automatic op(input logic [W-1:0] x,
                    input logic [W-1:0] y,
                    input logic s,
                    input bit wait_first,
                    input int poke);
    int cyc;
    int nb;
    if (wait_first) @(negedge clk);
    start = 1'b1;
    a     = x;
    b     = y;
    sub   = s;
    sb.push_back(model(x, y, s));
    @(negedge clk);
    cyc = 1;
    nb  = 0;
    while (done !== 1'b1 && cyc < 20) begin
      if (busy === 1'b1) nb++;
      if (cyc == poke) begin
        start = 1'b1;
        a     = ~x;
        b     = ~y;
        sub   = ~s;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("latency", 32'(cyc), W + 1);
    chk("busy_cycles", 32'(nb), W);
    chk("busy_at_done", 32'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_cout", 32'(cout), 0);
    chk("rst_ovf", 32'(overflow), 0);
    rst = 1'b0;

    op(8'd5, 8'd3, 1'b0, 1'b1, 0);
    @(negedge clk);
    chk("hold_result", 32'(result), 8);
    chk("hold_done", 32'(done), 0);
    chk("hold_busy", 32'(busy), 0);

    op(8'd200, 8'd100, 1'b0, 1'b1, 0);
    op(8'd127, 8'd1, 1'b0, 1'b1, 0);
    op(8'd5, 8'd3, 1'b1, 1'b1, 0);
    op(8'd3, 8'd5, 1'b1, 1'b1, 0);
    op(8'd128, 8'd1, 1'b1, 1'b1, 0);
    op(8'd0, 8'd0, 1'b1, 1'b1, 0);
    op(8'd255, 8'd1, 1'b0, 1'b1, 0);

    op(8'd5, 8'd3, 1'b0, 1'b1, 3);

    op(8'd9, 8'd4, 1'b0, 1'b1, 0);
    op(8'd100, 8'd27, 1'b1, 1'b0, 0);
    op(8'd60, 8'd70, 1'b0, 1'b0, 0);

    @(negedge clk);
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'h00;
    sub   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_result", 32'(result), 0);
    rst = 1'b0;
    nd  = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    chk("no_done", 32'(nd), 0);

    op(8'd5, 8'd3, 1'b0, 1'b1, 0);
    @(negedge clk);
    chk("final_result", 32'(result), 8);
    chk("sb_empty", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
